rr_fetch: RTL and testbench

Instruction fetch stage. It is the producer of the 32-bit instruction word consumed by the decode stage, and it consumes that stage's registered control-hazard stall.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Forwards returned words to decode; in every other cycle it drives a NOP bubble.
- Freezes on control-flow stalls until execute supplies the resolved target on the redirect port.

---
 rtl/rr_fetch_if.sv | 24 ++
 rtl/rr_fetch.sv | 126 ++++++++++++
 tb/tb_rr_fetch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_fetch_if.sv
// rr_fetch_if: instruction-memory request/response channel between fetch (master) and memory.
interface rr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/rr_fetch.sv
// rr_fetch: single-outstanding instruction fetch stage feeding decode, with stall/redirect control.
// Optional FETCH_EARLY_STALL_EN: park in hold right after forwarding a control-flow word.
module rr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  rr_fetch_if.master  imem,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {FReq, FWait, FDrain, FHold} state_e;

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        pend_q, pend_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & AlignMask;

`ifdef FETCH_EARLY_STALL_EN
  logic is_ctl;
  assign is_ctl = (imem.imem_rdata[6:0] == 7'b1100011) ||
                  (imem.imem_rdata[6:0] == 7'b1101111) ||
                  (imem.imem_rdata[6:0] == 7'b1100111);
`endif

  // Request is gated by reset so nothing is presented while the stage is held in reset.
  assign imem.imem_req  = reset_n && (state_q == FReq);
  assign imem.imem_addr = pc_q & AlignMask;
  assign inst           = inst_q;
  assign pc_out         = pc_out_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = NOP_INST;
    pc_out_d = pc_out_q;
    pend_d   = pend_q;
    unique case (state_q)
      FReq: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem.imem_ready) begin
            pend_d  = 1'b1;
            state_d = FDrain;
          end
        end else if (stall_in) begin
          state_d = imem.imem_ready ? FDrain : FHold;
        end else if (imem.imem_ready) begin
          state_d = FWait;
        end
      end
      FWait: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem.imem_valid) begin
            state_d = FReq;
          end else begin
            pend_d  = 1'b1;
            state_d = FDrain;
          end
        end else if (stall_in) begin
          state_d = imem.imem_valid ? FHold : FDrain;
        end else if (imem.imem_valid) begin
          inst_d   = imem.imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
`ifdef FETCH_EARLY_STALL_EN
          state_d  = is_ctl ? FHold : FReq;
`else
          state_d  = FReq;
`endif
        end
      end
      FDrain: begin
        // The outstanding word is wrong-path; a redirect only decides where to go once it lands.
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem.imem_valid) begin
            pend_d  = 1'b0;
            state_d = FReq;
          end else begin
            pend_d = 1'b1;
          end
        end else if (imem.imem_valid) begin
          pend_d  = 1'b0;
          state_d = pend_q ? FReq : FHold;
        end
      end
      FHold: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FReq;
        end
      end
      default: state_d = FReq;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FReq;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      pc_out_q <= RESET_PC;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_rr_fetch.sv
// tb_rr_fetch: randomized memory/decode/execute environment; forwarded instructions are scored
// against the architectural program-order stream derived from a fixed memory image.
module tb_rr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst;
  logic [31:0] pc_out;

  rr_fetch_if imem_bus ();

  rr_fetch #(
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem          (imem_bus),
    .stall_in      (stall_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst          (inst),
    .pc_out        (pc_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          forwards = 0;
  bit          ctl_seen = 1'b0;
  logic [31:0] last_fwd_pc = RST_PC;

  // Memory image: mostly R-type words, roughly 1 in 8 a branch/jal/jalr; never the NOP word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    if (x[31:29] == 3'd0) begin
      case (x[28:27])
        2'd0:    x[6:0] = 7'b1100011;
        2'd1:    x[6:0] = 7'b1101111;
        default: x[6:0] = 7'b1100111;
      endcase
    end else begin
      x[6:0] = 7'b0110011;
    end
    return x;
  endfunction

  function automatic bit is_ctl(input logic [31:0] w);
    return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
  endfunction

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.word = mem_word(a);
    exp_q.push_back(e);
  endtask

  // Monitor: anything other than NOP on inst is a forwarded word and is scored.
  always @(negedge clock) begin
    if (reset_n) begin
      if (inst !== NOP) begin
        forwards++;
        checks++;
        if (!(imem_bus.imem_valid === 1'b1 && imem_bus.imem_rdata === inst)) begin
          errors++;
          $display("FAIL fwd_latency: inst=%h, previous-cycle valid=%b rdata=%h",
                   inst, imem_bus.imem_valid, imem_bus.imem_rdata);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: got pc_out=%h inst=%h, expected no instruction",
                   pc_out, inst);
        end else begin
          mon_e = exp_q.pop_front();
          if (pc_out !== mon_e.pc || inst !== mon_e.word) begin
            errors++;
            $display("FAIL stream: got pc_out=%h inst=%h, expected pc_out=%h inst=%h",
                     pc_out, inst, mon_e.pc, mon_e.word);
          end
          last_fwd_pc = mon_e.pc;
          if (is_ctl(mon_e.word)) ctl_seen = 1'b1;
          else push_exp(mon_e.pc + 32'd4);
        end
      end else begin
        checks++;
        if (pc_out !== last_fwd_pc) begin
          errors++;
          $display("FAIL pc_out_hold: got %h, expected %h", pc_out, last_fwd_pc);
        end
      end
    end
  end

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    push_exp(t & 32'hFFFF_FFFC);
  endtask

  function automatic logic [31:0] pick_target(input logic [31:0] fall);
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0203;
      1:       return 32'hFFFF_FFFC;
      2:       return fall;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bit          busy;
    int          lat;
    logic [31:0] maddr;
    int          phase;
    int          wait_cnt;
    bit          prev_hold;
    logic [31:0] prev_addr;
    bit          did_reset;
    bit          directed;

    busy = 1'b0; lat = 0; maddr = 32'h0; phase = 0; wait_cnt = 0;
    prev_hold = 1'b0; prev_addr = 32'h0; did_reset = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b, expected 0", imem_bus.imem_req);
    end
    checks++;
    if (inst !== NOP) begin
      errors++; $display("FAIL reset_inst: got %h, expected %h", inst, NOP);
    end
    checks++;
    if (pc_out !== RST_PC) begin
      errors++; $display("FAIL reset_pc_out: got %h, expected %h", pc_out, RST_PC);
    end
    push_exp(RST_PC);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      #1;
      directed = (cyc < 40);

      // Asynchronous reset while a fetch is in flight.
      if (!did_reset && cyc >= 2000 && busy && phase == 0) begin
        did_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL async_reset_req: got %b, expected 0", imem_bus.imem_req);
        end
        checks++;
        if (inst !== NOP) begin
          errors++; $display("FAIL async_reset_inst: got %h, expected %h", inst, NOP);
        end
        busy = 1'b0; phase = 0; ctl_seen = 1'b0; prev_hold = 1'b0;
        exp_q.delete();
        last_fwd_pc = RST_PC;
        stall_in = 1'b0; redirect_valid = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_valid = 1'b0;
        @(negedge clock);
        #1;
        push_exp(RST_PC);
        reset_n = 1'b1;
        // Stale response in the first cycle after release must be ignored.
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        continue;
      end

      stall_in = 1'b0;
      redirect_valid = 1'b0;
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_ready = 1'b0;

      if (prev_hold) begin
        checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_hold: got req=%b addr=%h, expected req=1 addr=%h",
                   imem_bus.imem_req, imem_bus.imem_addr, prev_addr);
        end
      end
      if (busy) begin
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL single_outstanding: got req=%b, expected 0", imem_bus.imem_req);
        end
      end

      // Decode/execute model: stall the cycle after a control word shows, then redirect.
      if (phase == 0 && ctl_seen) begin
        ctl_seen = 1'b0;
        phase = 1;
`ifdef FETCH_EARLY_STALL_EN
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL early_stall_req: got %b, expected 0", imem_bus.imem_req);
        end
`endif
      end else if (phase == 1) begin
        stall_in = 1'b1;
        phase = 2;
        wait_cnt = int'($urandom_range(0, 4));
`ifdef FETCH_EARLY_STALL_EN
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL early_stall_req: got %b, expected 0", imem_bus.imem_req);
        end
`endif
      end else if (phase == 2) begin
        checks++;
        if (imem_bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL shadow_req: got %b, expected 0", imem_bus.imem_req);
        end
        if (wait_cnt == 0) begin
          do_redirect(pick_target(last_fwd_pc + 32'd4));
          phase = 0;
        end else begin
          wait_cnt--;
        end
      end else if (!directed && $urandom_range(0, 39) == 0) begin
        do_redirect(pick_target(last_fwd_pc + 32'd4));
      end

      // Memory: one response per accepted request, at least one cycle after acceptance.
      if (busy) begin
        if (lat == 0) begin
          imem_bus.imem_valid = 1'b1;
          imem_bus.imem_rdata = mem_word(maddr);
          busy = 1'b0;
        end else begin
          lat--;
        end
      end else begin
        if (directed) imem_bus.imem_ready = !(cyc >= 20 && cyc < 23);
        else imem_bus.imem_ready = ($urandom_range(0, 9) < 7);
        if (imem_bus.imem_req && imem_bus.imem_ready) begin
          busy = 1'b1;
          maddr = imem_bus.imem_addr;
          lat = directed ? 0 : int'($urandom_range(0, 3));
        end
      end

      prev_hold = imem_bus.imem_req && !imem_bus.imem_ready && !redirect_valid && !stall_in;
      prev_addr = imem_bus.imem_addr;
    end

    checks++;
    if (forwards < 200) begin
      errors++; $display("FAIL progress: got %0d forwarded words, expected at least 200", forwards);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
